// File: rtl/vc_arb_pkg.sv
// ---------------------------------------------------------------------------
// vc_arb_pkg
// Shared types and defaults for the virtual-channel arbitration-table
// sequencer: the sequencer state enum, default parameter values and the
// function that produces the reset-time table pattern.
// ---------------------------------------------------------------------------
package vc_arb_pkg;

    typedef enum logic {
        S_SCAN  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    localparam int NUM_VC_DEF      = 4;
    localparam int VC_W_DEF        = 2;
    localparam int TABLE_DEPTH_DEF = 64;
    localparam int ADDR_W_DEF      = 6;
    localparam int SKIP_EMPTY_DEF  = 1;

    // Reset pattern: entry i holds VC (i % num_vc), a plain round-robin.
    function automatic int default_entry(input int idx, input int num_vc);
        return idx % num_vc;
    endfunction

endpackage

// File: rtl/vc_table_mem.sv
// ---------------------------------------------------------------------------
// vc_table_mem
// Register array holding the arbitration table.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset, loads the round-robin pattern
//   enb_i      : global enable; 0 freezes the contents
//   init_i     : bulk-load strobe, takes priority over the single write
//   table_i    : bulk image, entry i at [i*VC_W +: VC_W]
//   wr_en_i    : single-entry write strobe
//   wr_addr_i  : single-entry index (indices >= TABLE_DEPTH are dropped)
//   wr_data_i  : single-entry value
//   rd_addr_i  : combinational read index
//   rd_data_o  : entry at rd_addr_i (pre-write value during a write cycle)
// ---------------------------------------------------------------------------
module vc_table_mem
    import vc_arb_pkg::*;
#(
    parameter int NUM_VC      = NUM_VC_DEF,
    parameter int VC_W        = VC_W_DEF,
    parameter int TABLE_DEPTH = TABLE_DEPTH_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enb_i,
    input  logic                          init_i,
    input  logic [TABLE_DEPTH*VC_W-1:0]   table_i,
    input  logic                          wr_en_i,
    input  logic [ADDR_W-1:0]             wr_addr_i,
    input  logic [VC_W-1:0]               wr_data_i,
    input  logic [ADDR_W-1:0]             rd_addr_i,
    output logic [VC_W-1:0]               rd_data_o
);

    logic [VC_W-1:0] mem_q [TABLE_DEPTH];
    logic            wr_ok;

    assign wr_ok = wr_en_i && (int'(wr_addr_i) < TABLE_DEPTH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                mem_q[i] <= VC_W'(default_entry(i, NUM_VC));
            end
        end else if (enb_i) begin
            if (init_i) begin
                for (int i = 0; i < TABLE_DEPTH; i++) begin
                    mem_q[i] <= table_i[i*VC_W +: VC_W];
                end
            end else if (wr_ok) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    // The read is combinational from the registers, so a same-cycle write
    // to the scanned entry is only visible from the following cycle.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/vc_arb_table_seq.sv
// ---------------------------------------------------------------------------
// vc_arb_table_seq
// Arbitration-table sequencer: walks a TABLE_DEPTH-entry table of VC numbers
// and issues one grant per valid/ready handshake. With SKIP_EMPTY=1 entries
// whose VC has no pending request are skipped.
//   clk         : clock
//   rst         : asynchronous active-low reset
//   enb         : global enable; 0 freezes state and outputs
//   init        : bulk-load strobe (table <= table_in, pointer to 0)
//   table_in    : bulk image, entry i at [i*VC_W +: VC_W]
//   wr_en       : single-entry write; wr_addr / wr_data give index and value
//   vc_req      : pending request per VC
//   grant_ready : downstream accepts the current grant
//   grant_valid : grant available; grant_vc / grant_addr stable while high
//   lap_done    : one-cycle pulse when the pointer wraps to 0
// ---------------------------------------------------------------------------
module vc_arb_table_seq
    import vc_arb_pkg::*;
#(
    parameter int NUM_VC      = NUM_VC_DEF,
    parameter int VC_W        = VC_W_DEF,
    parameter int TABLE_DEPTH = TABLE_DEPTH_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SKIP_EMPTY  = SKIP_EMPTY_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enb,
    input  logic                          init,
    input  logic [TABLE_DEPTH*VC_W-1:0]   table_in,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [VC_W-1:0]               wr_data,
    input  logic [NUM_VC-1:0]             vc_req,
    input  logic                          grant_ready,
    output logic                          grant_valid,
    output logic [VC_W-1:0]               grant_vc,
    output logic [ADDR_W-1:0]             grant_addr,
    output logic                          lap_done
);

    localparam int REQ_W = 2**VC_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                gv_q, gv_d;
    logic [VC_W-1:0]     gvc_q, gvc_d;
    logic [ADDR_W-1:0]   gaddr_q, gaddr_d;
    logic                lap_q, lap_d;

    logic [VC_W-1:0]     entry;
    logic [REQ_W-1:0]    req_pad;
    logic                entry_ok;
    logic                scan_en;
    logic                hit;
    logic                ptr_wrap;
    logic [ADDR_W-1:0]   ptr_next;

    vc_table_mem #(
        .NUM_VC      (NUM_VC),
        .VC_W        (VC_W),
        .TABLE_DEPTH (TABLE_DEPTH),
        .ADDR_W      (ADDR_W)
    ) u_mem (
        .clk_i     (clk),
        .rst_ni    (rst),
        .enb_i     (enb),
        .init_i    (init),
        .table_i   (table_in),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (ptr_q),
        .rd_data_o (entry)
    );

    // Pad the request vector to the full entry range so any entry value can
    // index it; entries >= NUM_VC are rejected separately by entry_ok.
    assign req_pad  = REQ_W'(vc_req);
    assign entry_ok = int'(entry) < NUM_VC;
    assign hit      = entry_ok && ((SKIP_EMPTY == 0) || req_pad[entry]);
    // With skipping enabled and nothing requested the pointer parks.
    assign scan_en  = (SKIP_EMPTY == 0) || (|vc_req);
    assign ptr_wrap = (ptr_q == ADDR_W'(TABLE_DEPTH - 1));
    assign ptr_next = ptr_wrap ? '0 : ptr_q + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (enb) begin
            if (init) begin
                state_d = S_SCAN;
            end else begin
                case (state_q)
                    S_SCAN:  if (scan_en && hit) state_d = S_GRANT;
                    S_GRANT: if (grant_ready)    state_d = S_SCAN;
                    default: state_d = S_SCAN;
                endcase
            end
        end
    end

    // Output / datapath next values
    always_comb begin
        ptr_d   = ptr_q;
        gv_d    = gv_q;
        gvc_d   = gvc_q;
        gaddr_d = gaddr_q;
        lap_d   = 1'b0;
        if (enb) begin
            if (init) begin
                ptr_d = '0;
                gv_d  = 1'b0;
            end else begin
                case (state_q)
                    S_SCAN: begin
                        if (scan_en) begin
                            ptr_d = ptr_next;
                            lap_d = ptr_wrap;
                            if (hit) begin
                                gv_d    = 1'b1;
                                gvc_d   = entry;
                                gaddr_d = ptr_q;
                            end
                        end
                    end
                    S_GRANT: begin
                        if (grant_ready) gv_d = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            gv_q    <= 1'b0;
            gvc_q   <= '0;
            gaddr_q <= '0;
            lap_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            gv_q    <= gv_d;
            gvc_q   <= gvc_d;
            gaddr_q <= gaddr_d;
            lap_q   <= lap_d;
        end
    end

    assign grant_valid = gv_q;
    assign grant_vc    = gvc_q;
    assign grant_addr  = gaddr_q;
    assign lap_done    = lap_q;

endmodule

// File: tb/tb_vc_arb_table_seq.sv
// ---------------------------------------------------------------------------
// tb_vc_arb_table_seq
// Directed bench for vc_arb_table_seq. Two instances share all inputs:
// u0 with SKIP_EMPTY=0 (grants every entry) and u1 with SKIP_EMPTY=1.
// ---------------------------------------------------------------------------
module tb_vc_arb_table_seq;

    localparam int NUM_VC = 4;
    localparam int VC_W   = 2;
    localparam int TD     = 64;
    localparam int AW     = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enb;
    logic                 init;
    logic [TD*VC_W-1:0]   table_in;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [VC_W-1:0]      wr_data;
    logic [NUM_VC-1:0]    vc_req;
    logic                 grant_ready;

    logic                 gv0, gv1;
    logic [VC_W-1:0]      gvc0, gvc1;
    logic [AW-1:0]        ga0, ga1;
    logic                 lap0, lap1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    vc_arb_table_seq #(
        .NUM_VC(NUM_VC), .VC_W(VC_W), .TABLE_DEPTH(TD), .ADDR_W(AW), .SKIP_EMPTY(0)
    ) u0 (
        .clk(clk), .rst(rst), .enb(enb), .init(init), .table_in(table_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .vc_req(vc_req),
        .grant_ready(grant_ready), .grant_valid(gv0), .grant_vc(gvc0),
        .grant_addr(ga0), .lap_done(lap0)
    );

    vc_arb_table_seq #(
        .NUM_VC(NUM_VC), .VC_W(VC_W), .TABLE_DEPTH(TD), .ADDR_W(AW), .SKIP_EMPTY(1)
    ) u1 (
        .clk(clk), .rst(rst), .enb(enb), .init(init), .table_in(table_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .vc_req(vc_req),
        .grant_ready(grant_ready), .grant_valid(gv1), .grant_vc(gvc1),
        .grant_addr(ga1), .lap_done(lap1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_table(input bit all_three);
        for (int i = 0; i < TD; i++) begin
            table_in[i*VC_W +: VC_W] = all_three ? VC_W'(3) : VC_W'(i % NUM_VC);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; enb = 1'b0; init = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; vc_req = '0; grant_ready = 1'b0; table_in = '0;
        #12;
        chk_cnt++;
        if ({gv0, gvc0, ga0, lap0, gv1, gvc1, ga1, lap1} !== '0)
            $display("FAIL reset_outputs: got gv0=%b vc0=%0d a0=%0d lap0=%b gv1=%b vc1=%0d a1=%0d lap1=%b, want all 0",
                     gv0, gvc0, ga0, lap0, gv1, gvc1, ga1, lap1);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        chk_cnt++;
        if (gv0 !== 1'b0 || gv1 !== 1'b0)
            $display("FAIL enb0_idle: got gv0=%b gv1=%b, want 0 0", gv0, gv1);
        else pass_cnt++;
    endtask

    // Default table, every entry granted in order, one grant per 2 cycles.
    task automatic test_noskip_lap();
        enb = 1'b1; grant_ready = 1'b1; vc_req = '0;
        for (int k = 0; k < TD; k++) begin
            tick();
            chk_cnt++;
            if (gv0 !== 1'b1 || gvc0 !== VC_W'(k % NUM_VC) || ga0 !== AW'(k) || lap0 !== (k == TD - 1))
                $display("FAIL noskip_grant k=%0d: got gv=%b vc=%0d addr=%0d lap=%b, want 1 %0d %0d %0d",
                         k, gv0, gvc0, ga0, lap0, k % NUM_VC, k, (k == TD - 1));
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (gv0 !== 1'b0 || lap0 !== 1'b0)
                $display("FAIL noskip_gap k=%0d: got gv=%b lap=%b, want 0 0", k, gv0, lap0);
            else pass_cnt++;
        end
        // u1 saw no requests at all, so it must never have granted.
        chk_cnt++;
        if (gv1 !== 1'b0 || ga1 !== '0)
            $display("FAIL skip_noreq_idle: got gv=%b addr=%0d, want 0 0", gv1, ga1);
        else pass_cnt++;
    endtask

    // Bulk load of all-3 with a simultaneous wr_en to entry 0 (init wins).
    task automatic test_bulk_load();
        set_table(1'b1);
        vc_req = 4'b1000;
        init = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = '0;
        tick();
        init = 1'b0; wr_en = 1'b0;
        chk_cnt++;
        if (gv0 !== 1'b0 || gv1 !== 1'b0)
            $display("FAIL bulk_init_clear: got gv0=%b gv1=%b, want 0 0", gv0, gv1);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_cnt++;
            if (gv0 !== 1'b1 || gvc0 !== 2'd3 || ga0 !== AW'(k) ||
                gv1 !== 1'b1 || gvc1 !== 2'd3 || ga1 !== AW'(k))
                $display("FAIL bulk_grant k=%0d: got u0 %b/%0d/%0d u1 %b/%0d/%0d, want 1/3/%0d",
                         k, gv0, gvc0, ga0, gv1, gvc1, ga1, k);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (gv0 !== 1'b0 || gv1 !== 1'b0)
                $display("FAIL bulk_gap k=%0d: got gv0=%b gv1=%b, want 0 0", k, gv0, gv1);
            else pass_cnt++;
        end
    endtask

    // Default table, only VC2 requesting: u1 grants at 2,6,10,14 exactly.
    task automatic test_skip_empty();
        set_table(1'b0);
        vc_req = 4'b0100;
        init = 1'b1;
        tick();
        init = 1'b0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < ((j == 0) ? 2 : 4); i++) begin
                tick();
                chk_cnt++;
                if (gv1 !== 1'b0)
                    $display("FAIL skip_miss j=%0d i=%0d: got gv=%b, want 0", j, i, gv1);
                else pass_cnt++;
            end
            tick();
            chk_cnt++;
            if (gv1 !== 1'b1 || gvc1 !== 2'd2 || ga1 !== AW'(4*j + 2))
                $display("FAIL skip_hit j=%0d: got gv=%b vc=%0d addr=%0d, want 1 2 %0d",
                         j, gv1, gvc1, ga1, 4*j + 2);
            else pass_cnt++;
        end
        // No requests: pointer parks at 15 and nothing is granted.
        vc_req = '0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_cnt++;
            if (gv1 !== 1'b0)
                $display("FAIL skip_frozen i=%0d: got gv=%b, want 0", i, gv1);
            else pass_cnt++;
        end
        vc_req = 4'b1000;
        tick();
        chk_cnt++;
        if (gv1 !== 1'b1 || gvc1 !== 2'd3 || ga1 !== AW'(15))
            $display("FAIL skip_resume: got gv=%b vc=%0d addr=%0d, want 1 3 15", gv1, gvc1, ga1);
        else pass_cnt++;
    endtask

    // Backpressure: grant held stable while vc_req toggles.
    task automatic test_hold();
        grant_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vc_req = (i % 2 == 0) ? 4'b0000 : 4'b1111;
            tick();
            chk_cnt++;
            if (gv1 !== 1'b1 || gvc1 !== 2'd3 || ga1 !== AW'(15))
                $display("FAIL hold_stable i=%0d: got gv=%b vc=%0d addr=%0d, want 1 3 15", i, gv1, gvc1, ga1);
            else pass_cnt++;
        end
        grant_ready = 1'b1;
        tick();
        chk_cnt++;
        if (gv1 !== 1'b0)
            $display("FAIL hold_release: got gv=%b, want 0", gv1);
        else pass_cnt++;
    endtask

    // Write to entry 5 on the very cycle entry 5 is scanned. The new value
    // (3) differs from the default (1) so old/new are distinguishable.
    task automatic test_write_collision();
        set_table(1'b0);
        vc_req = 4'b1111;
        init = 1'b1;
        tick();
        init = 1'b0;
        repeat (10) tick();
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = 2'd3;
        tick();
        wr_en = 1'b0;
        chk_cnt++;
        if (gv0 !== 1'b1 || ga0 !== AW'(5) || gvc0 !== 2'd1 || gv1 !== 1'b1 || gvc1 !== 2'd1)
            $display("FAIL wr_old_value: got u0 %b/%0d/%0d u1 %b/%0d, want 1/5/1 and 1/1",
                     gv0, ga0, gvc0, gv1, gvc1);
        else pass_cnt++;
        repeat (127) tick();
        tick();
        chk_cnt++;
        if (gv0 !== 1'b1 || ga0 !== AW'(5) || gvc0 !== 2'd3 || gv1 !== 1'b1 || gvc1 !== 2'd3)
            $display("FAIL wr_new_value: got u0 %b/%0d/%0d u1 %b/%0d, want 1/5/3 and 1/3",
                     gv0, ga0, gvc0, gv1, gvc1);
        else pass_cnt++;
    endtask

    // Async reset in the middle of a grant, then enable freeze.
    task automatic test_reset_mid_grant();
        tick();
        set_table(1'b1);
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
        chk_cnt++;
        if (gv0 !== 1'b1 || gvc0 !== 2'd3 || ga0 !== '0)
            $display("FAIL rst_pre_grant: got gv=%b vc=%0d addr=%0d, want 1 3 0", gv0, gvc0, ga0);
        else pass_cnt++;
        grant_ready = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (gv0 !== 1'b0 || gv1 !== 1'b0 || gvc0 !== '0 || ga0 !== '0)
            $display("FAIL rst_async_drop: got gv0=%b gv1=%b vc0=%0d a0=%0d, want 0 0 0 0",
                     gv0, gv1, gvc0, ga0);
        else pass_cnt++;
        #1;
        rst = 1'b1;
        grant_ready = 1'b1;
        tick();
        chk_cnt++;
        if (gv0 !== 1'b1 || gvc0 !== 2'd0 || ga0 !== '0)
            $display("FAIL rst_first_grant: got gv=%b vc=%0d addr=%0d, want 1 0 0", gv0, gvc0, ga0);
        else pass_cnt++;
        enb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++;
            if (gv0 !== 1'b1 || gvc0 !== 2'd0 || ga0 !== '0 || lap0 !== 1'b0)
                $display("FAIL enb_freeze i=%0d: got gv=%b vc=%0d addr=%0d lap=%b, want 1 0 0 0",
                         i, gv0, gvc0, ga0, lap0);
            else pass_cnt++;
        end
        enb = 1'b1;
        tick();
        chk_cnt++;
        if (gv0 !== 1'b0)
            $display("FAIL enb_resume_drop: got gv=%b, want 0", gv0);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (gv0 !== 1'b1 || gvc0 !== 2'd1 || ga0 !== AW'(1))
            $display("FAIL rst_default_table: got gv=%b vc=%0d addr=%0d, want 1 1 1", gv0, gvc0, ga0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_noskip_lap();
        test_bulk_load();
        test_skip_empty();
        test_hold();
        test_write_collision();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
